report_ascii_multi: RTL and testbench

REPORT_ASCII_MULTI -- requirements
Module: report_ascii_multi

---
 rtl/report_ascii_multi.sv | 169 ++++++++++++++++
 tb/tb_report_ascii_multi.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/report_ascii_multi.sv
// Periodic / on-demand ASCII report generator: emits "SSS c0=XXXX c1=XXXX...\r\n"
// one byte per valid&ready handshake, using counter values snapshotted at line start.
module report_ascii_multi #(
  parameter int CLK_FREQ    = 50_000_000,
  parameter int REPORT_FREQ = 2,
  parameter int NUM_CH      = 2,
  parameter int CNT_WIDTH   = 32,
  parameter int SEQ_DIGITS  = 3
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        enable,
  input  logic                        trigger,
  input  logic [NUM_CH*CNT_WIDTH-1:0] counters,
  output logic [7:0]                  data,
  output logic                        valid,
  input  logic                        ready,
  output logic                        busy,
  output logic                        dropped
);

  localparam int REPORT_COUNT = CLK_FREQ / REPORT_FREQ;
  localparam int PW           = $clog2(REPORT_COUNT);
  localparam int ND           = CNT_WIDTH / 4;
  localparam int SW           = 4 * SEQ_DIGITS;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEQ,
    S_LABEL,
    S_DIGIT,
    S_CR,
    S_LF
  } state_t;

  state_t                      state_q, state_d;
  logic [3:0]                  idx_q, idx_d;
  logic [3:0]                  ch_q, ch_d;
  logic [PW-1:0]               per_q;
  logic [SW-1:0]               seq_q, seq_snap_q;
  logic [NUM_CH*CNT_WIDTH-1:0] snap_q;
  logic                        tick, start, xfer;
  logic [3:0]                  seq_nib, cnt_nib;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    else           return 8'h37 + {4'h0, n};
  endfunction

  assign tick    = enable && (per_q == PW'(REPORT_COUNT - 1));
  assign valid   = (state_q != S_IDLE);
  assign busy    = valid;
  assign start   = !valid && (tick || trigger);
  // Requests that arrive mid-line are not queued, only flagged.
  assign dropped = valid && (tick || trigger);
  assign xfer    = valid && ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                per_q <= '0;
    else if (!enable || tick)  per_q <= '0;
    else                       per_q <= per_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seq_q      <= '0;
      seq_snap_q <= '0;
      snap_q     <= '0;
    end else if (start) begin
      snap_q     <= counters;
      seq_snap_q <= seq_q;
      seq_q      <= seq_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      ch_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ch_q    <= ch_d;
    end
  end

  always_comb begin
    seq_nib = '0;
    for (int d = 0; d < SEQ_DIGITS; d++)
      if (idx_q == 4'(d)) seq_nib = seq_snap_q[4*(SEQ_DIGITS-1-d) +: 4];
  end

  always_comb begin
    cnt_nib = '0;
    for (int k = 0; k < NUM_CH; k++)
      for (int d = 0; d < ND; d++)
        if (ch_q == 4'(k) && idx_q == 4'(d))
          cnt_nib = snap_q[k*CNT_WIDTH + 4*(ND-1-d) +: 4];
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ch_d    = ch_q;
    data    = 8'h00;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SEQ;
          idx_d   = '0;
          ch_d    = '0;
        end
      end
      S_SEQ: begin
        data = hex_char(seq_nib);
        if (xfer) begin
          if (idx_q == 4'(SEQ_DIGITS - 1)) begin
            state_d = S_LABEL;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      S_LABEL: begin
        case (idx_q)
          4'd0:    data = 8'h20;
          4'd1:    data = 8'h63;
          4'd2:    data = hex_char(ch_q);
          default: data = 8'h3D;
        endcase
        if (xfer) begin
          if (idx_q == 4'd3) begin
            state_d = S_DIGIT;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      S_DIGIT: begin
        data = hex_char(cnt_nib);
        if (xfer) begin
          idx_d = idx_q + 1'b1;
          if (idx_q == 4'(ND - 1)) begin
            idx_d = '0;
            if (ch_q == 4'(NUM_CH - 1)) begin
              state_d = S_CR;
            end else begin
              state_d = S_LABEL;
              ch_d    = ch_q + 1'b1;
            end
          end
        end
      end
      S_CR: begin
        data = 8'h0D;
        if (xfer) state_d = S_LF;
      end
      S_LF: begin
        data = 8'h0A;
        if (xfer) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_report_ascii_multi.sv
// Directed bench for report_ascii_multi: a 2-channel instance on a 100-cycle period
// and a 1-digit-sequence instance used for back-to-back lines and sequence wrap.
module tb_report_ascii_multi;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, enable, trigger, ready;
  logic [31:0] counters;
  logic [7:0]  data;
  logic        valid, busy, dropped;

  logic        trigger1, ready1, enable1;
  logic [3:0]  counters1;
  logic [7:0]  data1;
  logic        valid1, busy1, dropped1;

  report_ascii_multi #(
    .CLK_FREQ(100), .REPORT_FREQ(1), .NUM_CH(2), .CNT_WIDTH(16), .SEQ_DIGITS(3)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .trigger(trigger),
    .counters(counters), .data(data), .valid(valid), .ready(ready),
    .busy(busy), .dropped(dropped)
  );

  report_ascii_multi #(
    .CLK_FREQ(1000), .REPORT_FREQ(1), .NUM_CH(1), .CNT_WIDTH(4), .SEQ_DIGITS(1)
  ) u_dut1 (
    .clk(clk), .rst_n(rst_n), .enable(enable1), .trigger(trigger1),
    .counters(counters1), .data(data1), .valid(valid1), .ready(ready1),
    .busy(busy1), .dropped(dropped1)
  );

  int    n_tests = 0;
  int    n_fail  = 0;
  int    cyc     = 0;
  int    drop_cnt = 0;
  string lines[$];
  int    first_cyc[$];
  int    durs[$];
  string cur = "";
  int    cur_first = 0;
  string lines1[$];
  int    first1[$];
  string cur1 = "";
  int    cur1_first = 0;
  logic  pv = 1'b0, pr = 1'b0, prst = 1'b0;
  logic [7:0] pd = 8'h00;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input string got, input string exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %s expected %s", tag, got, exp);
    end
  endtask

  function automatic string vis(input string s);
    string r = "";
    for (int i = 0; i < s.len(); i++) begin
      if (s[i] == 8'h0D)      r = {r, "\\r"};
      else if (s[i] == 8'h0A) r = {r, "\\n"};
      else                    r = {r, s.substr(i, i)};
    end
    return r;
  endfunction

  function automatic string d2s(input int v);
    return $sformatf("%0d", v);
  endfunction

  // Byte collectors; sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      cur = "";
    end else begin
      if (prst && pv && !pr && valid)
        chk("stall_hold", $sformatf("%02h", data), $sformatf("%02h", pd));
      if (dropped) drop_cnt++;
      if (valid && ready) begin
        if (cur.len() == 0) cur_first = cyc;
        cur = $sformatf("%s%c", cur, data);
        if (data == 8'h0A) begin
          lines.push_back(cur);
          first_cyc.push_back(cur_first);
          durs.push_back(cyc - cur_first + 1);
          cur = "";
        end
      end
    end
    pv = valid; pr = ready; pd = data; prst = rst_n;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      cur1 = "";
    end else if (valid1 && ready1) begin
      if (cur1.len() == 0) cur1_first = cyc;
      cur1 = $sformatf("%s%c", cur1, data1);
      if (data1 == 8'h0A) begin
        lines1.push_back(cur1);
        first1.push_back(cur1_first);
        cur1 = "";
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_lines(input int n, input int budget, input string tag);
    int k = 0;
    while (lines.size() < n && k < budget) begin
      step(1);
      k++;
    end
    if (lines.size() < n) chk(tag, "timeout", "line");
  endtask

  task automatic chk_line(input string tag, input int i, input string exp);
    if (lines.size() > i) chk(tag, vis(lines[i]), vis(exp));
    else                  chk(tag, "missing", vis(exp));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, c, k, db, ts;
    rst_n = 1'b0; enable = 1'b0; trigger = 1'b1; ready = 1'b1;
    counters = {16'h00AF, 16'h1234};
    trigger1 = 1'b0; ready1 = 1'b1; enable1 = 1'b0; counters1 = 4'hA;
    step(3);
    chk("rst_valid",   $sformatf("%0b", valid),   "0");
    chk("rst_busy",    $sformatf("%0b", busy),    "0");
    chk("rst_data",    $sformatf("%02h", data),   "00");
    chk("rst_dropped", $sformatf("%0b", dropped), "0");
    trigger = 1'b0;
    step(1);
    rst_n = 1'b1; enable = 1'b1; t0 = cyc;

    // periodic lines, counter change and enable drop mid-line
    wait_lines(1, 200, "line0_wait");
    chk_line("line0", 0, "000 c0=1234 c1=00AF\r\n");
    if (lines.size() > 0) begin
      chk("line0_lat", d2s(first_cyc[0] - t0), "100");
      chk("line0_len", d2s(durs[0]), "21");
    end
    while (cyc < t0 + 201) step(1);
    counters = {16'hBEEF, 16'hC0DE};
    wait_lines(2, 200, "line1_wait");
    chk_line("line1", 1, "001 c0=1234 c1=00AF\r\n");
    if (lines.size() > 1) chk("line1_lat", d2s(first_cyc[1] - t0), "200");
    while (cyc < t0 + 305) step(1);
    enable = 1'b0;
    wait_lines(3, 200, "line2_wait");
    chk_line("line2", 2, "002 c0=C0DE c1=BEEF\r\n");
    if (lines.size() > 2) chk("line2_len", d2s(durs[2]), "21");
    step(250);
    chk("no_periodic", d2s(lines.size()), "3");

    // on-demand trigger while disabled
    c = cyc;
    trigger = 1'b1; step(1); trigger = 1'b0;
    wait_lines(4, 100, "trig_wait");
    chk_line("trig_line", 3, "003 c0=C0DE c1=BEEF\r\n");
    if (lines.size() > 3) chk("trig_lat", d2s(first_cyc[3] - c), "1");
    step(300);
    chk("trig_only_one", d2s(lines.size()), "4");

    // random back-pressure
    trigger = 1'b1; step(1); trigger = 1'b0;
    k = 0;
    while (lines.size() < 5 && k < 300) begin
      ready = 1'($urandom_range(0, 1));
      step(1);
      k++;
    end
    ready = 1'b1;
    wait_lines(5, 50, "rand_wait");
    chk_line("rand_line", 4, "004 c0=C0DE c1=BEEF\r\n");

    // long stall across a tick
    db = drop_cnt;
    ready = 1'b0; enable = 1'b1;
    k = 0;
    while (!valid && k < 150) begin step(1); k++; end
    chk("stall_start", $sformatf("%0b", valid), "1");
    ts = cyc;
    step(150);
    ready = 1'b1;
    wait_lines(6, 50, "stall_wait");
    enable = 1'b0;
    chk_line("stall_line", 5, "005 c0=C0DE c1=BEEF\r\n");
    chk("stall_drops", d2s(drop_cnt - db), "1");
    step(50);
    chk("stall_no_queue", d2s(lines.size()), "6");
    chk("stall_idle", $sformatf("%0b", valid), "0");

    // asynchronous reset mid-line, then tick and trigger together
    trigger = 1'b1; step(1); trigger = 1'b0;
    k = 0;
    while (cur.len() < 7 && k < 50) begin step(1); k++; end
    chk("abort_pos", d2s(cur.len()), "7");
    rst_n = 1'b0;
    #1;
    chk("abort_valid", $sformatf("%0b", valid), "0");
    chk("abort_busy",  $sformatf("%0b", busy),  "0");
    chk("abort_data",  $sformatf("%02h", data), "00");
    step(2);
    rst_n = 1'b1; enable = 1'b1; t0 = cyc; db = drop_cnt;
    while (cyc < t0 + 99) step(1);
    trigger = 1'b1; step(1); trigger = 1'b0;
    wait_lines(7, 100, "post_rst_wait");
    enable = 1'b0;
    chk_line("post_rst_line", 6, "000 c0=C0DE c1=BEEF\r\n");
    if (lines.size() > 6) chk("post_rst_lat", d2s(first_cyc[6] - t0), "100");
    chk("tick_trig_nodrop", d2s(drop_cnt - db), "0");
    step(150);
    chk("tick_trig_one", d2s(lines.size()), "7");

    // back-to-back lines and sequence wrap on the single-digit instance
    trigger1 = 1'b1;
    k = 0;
    while (lines1.size() < 17 && k < 400) begin step(1); k++; end
    trigger1 = 1'b0;
    chk("wrap_count", d2s(lines1.size() >= 17 ? 17 : lines1.size()), "17");
    if (lines1.size() >= 17) begin
      chk("wrap_first", vis(lines1[0]),  vis("0 c0=A\r\n"));
      chk("wrap_last",  vis(lines1[15]), vis("F c0=A\r\n"));
      chk("wrap_roll",  vis(lines1[16]), vis("0 c0=A\r\n"));
      chk("b2b_gap0",   d2s(first1[1] - first1[0]),   "9");
      chk("b2b_gap15",  d2s(first1[16] - first1[15]), "9");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
